// File: rtl/my_mem_pkg.sv
// Shared types and helpers for the parity-memory read checker.
// The optional first-error log is enabled with MY_MEM_ERR_LOG_EN.
package my_mem_pkg;

    localparam int ADDR_W = 16;
    localparam int DATA_W = 8;
    localparam int PAR_W  = DATA_W + 1;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
        logic              perr;
    } rd_entry_t;

    // Even parity over the full stored word: nonzero means the word is corrupt.
    function automatic logic even_par(input logic [PAR_W-1:0] word);
        return ^word;
    endfunction

endpackage

// File: rtl/my_mem_rd_fifo.sv
// DEPTH-entry FIFO of checked read returns; a push while full is only
// accepted when the head is being popped in the same cycle.
module my_mem_rd_fifo
    import my_mem_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       i_push,
    input  rd_entry_t                  i_entry,
    input  logic                       i_pop,
    output rd_entry_t                  o_head,
    output logic                       o_full,
    output logic                       o_empty,
    output logic [$clog2(DEPTH+1)-1:0] o_level
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = $clog2(DEPTH+1);

    rd_entry_t        r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [LVL_W-1:0] r_level;

    logic             w_pop_ok;
    logic             w_push_ok;
    logic [LVL_W-1:0] w_level_nxt;

    assign o_full    = (r_level == LVL_W'(DEPTH));
    assign o_empty   = (r_level == {LVL_W{1'b0}});
    assign o_level   = r_level;
    assign o_head    = r_mem[r_rd_ptr];
    assign w_pop_ok  = i_pop && !o_empty;
    assign w_push_ok = i_push && (!o_full || w_pop_ok);

    // Occupancy follows the accepted push/pop pair.
    always_comb begin
        w_level_nxt = r_level;
        case ({w_push_ok, w_pop_ok})
            2'b10:   w_level_nxt = r_level + LVL_W'(1);
            2'b01:   w_level_nxt = r_level - LVL_W'(1);
            default: w_level_nxt = r_level;
        endcase
    end

    // Storage, pointers and level; pointers wrap naturally since DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_wr_ptr <= {PTR_W{1'b0}};
            r_rd_ptr <= {PTR_W{1'b0}};
            r_level  <= {LVL_W{1'b0}};
        end else begin
            if (w_push_ok) begin
                r_mem[r_wr_ptr] <= i_entry;
                r_wr_ptr        <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop_ok) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            r_level <= w_level_nxt;
        end
    end

endmodule

// File: rtl/my_mem_rd_checker.sv
// Read-return checker: latency pipe, parity check, result FIFO, error counter
// and overflow flag. Define MY_MEM_ERR_LOG_EN to add the first-error address log.
module my_mem_rd_checker
    import my_mem_pkg::*;
#(
    parameter int RD_LAT = 1,
    parameter int DEPTH  = 4,
    parameter int ERR_W  = 16
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       mem_read,
    input  logic [ADDR_W-1:0]          mem_address,
    input  logic [PAR_W-1:0]           mem_data_out,
    input  logic                       clear_err,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [ADDR_W-1:0]          out_address,
    output logic [DATA_W-1:0]          out_data,
    output logic                       out_perr,
    output logic [$clog2(DEPTH+1)-1:0] fifo_level,
    output logic [ERR_W-1:0]           error_count,
    output logic                       overflow
`ifdef MY_MEM_ERR_LOG_EN
    ,
    output logic                       first_err_valid,
    output logic [ADDR_W-1:0]          first_err_addr
`endif
);

    localparam logic [ERR_W-1:0] ERR_MAX = {ERR_W{1'b1}};

    logic [RD_LAT-1:0] r_pipe_vld;
    logic [ADDR_W-1:0] r_pipe_addr [RD_LAT];
    logic [ERR_W-1:0]  r_err_cnt;
    logic              r_overflow;

    logic              w_ret;
    logic              w_perr;
    logic              w_pop;
    logic              w_drop;
    logic              w_full;
    logic              w_empty;
    rd_entry_t         w_entry;
    rd_entry_t         w_head;
    logic [ERR_W-1:0]  w_cnt_nxt;

    // Address travels alongside the strobe so the return can be tagged on arrival.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pipe_vld <= {RD_LAT{1'b0}};
            for (int i = 0; i < RD_LAT; i++) begin
                r_pipe_addr[i] <= {ADDR_W{1'b0}};
            end
        end else begin
            for (int i = RD_LAT - 1; i > 0; i--) begin
                r_pipe_vld[i]  <= r_pipe_vld[i-1];
                r_pipe_addr[i] <= r_pipe_addr[i-1];
            end
            r_pipe_vld[0]  <= mem_read;
            r_pipe_addr[0] <= mem_address;
        end
    end

    assign w_ret   = r_pipe_vld[RD_LAT-1];
    assign w_perr  = w_ret && even_par(mem_data_out);
    assign w_entry = '{addr: r_pipe_addr[RD_LAT-1],
                       data: mem_data_out[DATA_W-1:0],
                       perr: even_par(mem_data_out)};
    assign w_pop   = out_valid && out_ready;
    assign w_drop  = w_ret && w_full && !w_pop;

    my_mem_rd_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (w_ret),
        .i_entry (w_entry),
        .i_pop   (w_pop),
        .o_head  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_level (fifo_level)
    );

    assign out_valid   = !w_empty;
    assign out_address = w_head.addr;
    assign out_data    = w_head.data;
    assign out_perr    = w_head.perr;

    // Saturating error count; an error arriving with clear_err survives the clear.
    always_comb begin
        w_cnt_nxt = r_err_cnt;
        if (clear_err) begin
            w_cnt_nxt = ERR_W'(w_perr);
        end else if (w_perr && (r_err_cnt != ERR_MAX)) begin
            w_cnt_nxt = r_err_cnt + ERR_W'(1'b1);
        end else begin
            w_cnt_nxt = r_err_cnt;
        end
    end

    // Counter and sticky overflow registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_err_cnt  <= {ERR_W{1'b0}};
            r_overflow <= 1'b0;
        end else begin
            r_err_cnt  <= w_cnt_nxt;
            r_overflow <= w_drop || (r_overflow && !clear_err);
        end
    end

    assign error_count = r_err_cnt;
    assign overflow    = r_overflow;

`ifdef MY_MEM_ERR_LOG_EN
    logic              r_first_vld;
    logic [ADDR_W-1:0] r_first_addr;

    // Latch the address of the first corrupt return since reset or clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_first_vld  <= 1'b0;
            r_first_addr <= {ADDR_W{1'b0}};
        end else if (clear_err) begin
            r_first_vld  <= w_perr;
            r_first_addr <= w_perr ? w_entry.addr : {ADDR_W{1'b0}};
        end else if (w_perr && !r_first_vld) begin
            r_first_vld  <= 1'b1;
            r_first_addr <= w_entry.addr;
        end else begin
            r_first_vld  <= r_first_vld;
            r_first_addr <= r_first_addr;
        end
    end

    assign first_err_valid = r_first_vld;
    assign first_err_addr  = r_first_addr;
`endif

endmodule

// File: tb/tb_my_mem_rd_checker.sv
// Bench for my_mem_rd_checker: directed scenarios then random traffic against a
// queue-based reference model. Build with MY_MEM_ERR_LOG_EN to also check the error log.
module tb_my_mem_rd_checker;

    localparam int RD_LAT = 1;
    localparam int DEPTH  = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        mem_read = 1'b0;
    logic [15:0] mem_address = 16'h0000;
    logic [8:0]  mem_data_out = 9'h000;
    logic        clear_err = 1'b0;
    logic        out_ready = 1'b0;

    logic        a_valid, b_valid;
    logic [15:0] a_addr, b_addr;
    logic [7:0]  a_data, b_data;
    logic        a_perr, b_perr;
    logic [2:0]  a_level, b_level;
    logic [15:0] a_cnt;
    logic [1:0]  b_cnt;
    logic        a_ovf, b_ovf;
`ifdef MY_MEM_ERR_LOG_EN
    logic        a_fev, b_fev;
    logic [15:0] a_fea, b_fea;
`endif

    my_mem_rd_checker #(.RD_LAT(RD_LAT), .DEPTH(DEPTH), .ERR_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .mem_read(mem_read), .mem_address(mem_address),
        .mem_data_out(mem_data_out), .clear_err(clear_err), .out_valid(a_valid),
        .out_ready(out_ready), .out_address(a_addr), .out_data(a_data), .out_perr(a_perr),
        .fifo_level(a_level), .error_count(a_cnt), .overflow(a_ovf)
`ifdef MY_MEM_ERR_LOG_EN
        , .first_err_valid(a_fev), .first_err_addr(a_fea)
`endif
    );

    my_mem_rd_checker #(.RD_LAT(RD_LAT), .DEPTH(DEPTH), .ERR_W(2)) dut_sat (
        .clk(clk), .rst_n(rst_n), .mem_read(mem_read), .mem_address(mem_address),
        .mem_data_out(mem_data_out), .clear_err(clear_err), .out_valid(b_valid),
        .out_ready(out_ready), .out_address(b_addr), .out_data(b_data), .out_perr(b_perr),
        .fifo_level(b_level), .error_count(b_cnt), .overflow(b_ovf)
`ifdef MY_MEM_ERR_LOG_EN
        , .first_err_valid(b_fev), .first_err_addr(b_fea)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {logic [15:0] addr; logic [7:0] data; bit perr;} ent_t;
    typedef struct {int due; logic [15:0] addr;} pend_t;

    ent_t        m_fifo[$];
    pend_t       m_pend[$];
    int          m_edge;
    int          m_cnt16, m_cnt2;
    bit          m_ovf;
    bit          m_log_v;
    logic [15:0] m_log_a;

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [8:0] word(input logic [7:0] d, input bit bad);
        return {(^d) ^ bad, d};
    endfunction

    task automatic model_reset();
        m_fifo.delete();
        m_pend.delete();
        m_cnt16 = 0;
        m_cnt2  = 0;
        m_ovf   = 0;
        m_log_v = 0;
        m_log_a = 16'h0000;
    endtask

    // Reference behaviour for one rising edge, from the inputs driven before it.
    task automatic model_update();
        bit   pop, ret, perr, drop;
        ent_t e;
        m_edge++;
        pop = (m_fifo.size() > 0) && out_ready;
        ret = 0;
        e.addr = 16'h0000;
        if (m_pend.size() > 0 && m_pend[0].due == m_edge) begin
            ret = 1;
            e.addr = m_pend[0].addr;
            void'(m_pend.pop_front());
        end
        e.data = mem_data_out[7:0];
        e.perr = ^mem_data_out;
        perr = ret && e.perr;
        drop = ret && (m_fifo.size() == DEPTH) && !pop;
        if (pop) void'(m_fifo.pop_front());
        if (ret && !drop) m_fifo.push_back(e);
        if (clear_err) begin
            m_cnt16 = perr ? 1 : 0;
            m_cnt2  = perr ? 1 : 0;
        end else if (perr) begin
            m_cnt16 = (m_cnt16 < 65535) ? m_cnt16 + 1 : 65535;
            m_cnt2  = (m_cnt2 < 3) ? m_cnt2 + 1 : 3;
        end
        m_ovf = drop ? 1'b1 : (clear_err ? 1'b0 : m_ovf);
        if (clear_err) begin
            m_log_v = perr;
            m_log_a = perr ? e.addr : 16'h0000;
        end else if (perr && !m_log_v) begin
            m_log_v = 1;
            m_log_a = e.addr;
        end
        if (mem_read) m_pend.push_back('{due: m_edge + RD_LAT, addr: mem_address});
    endtask

    task automatic compare_all();
        chk("out_valid", a_valid, m_fifo.size() > 0);
        chk("fifo_level", a_level, m_fifo.size());
        chk("overflow", a_ovf, m_ovf);
        chk("error_count", a_cnt, m_cnt16);
        chk("sat_error_count", b_cnt, m_cnt2);
        chk("sat_overflow", b_ovf, m_ovf);
        if (m_fifo.size() > 0) begin
            chk("out_address", a_addr, m_fifo[0].addr);
            chk("out_data", a_data, m_fifo[0].data);
            chk("out_perr", a_perr, m_fifo[0].perr);
        end
`ifdef MY_MEM_ERR_LOG_EN
        chk("first_err_valid", a_fev, m_log_v);
        chk("first_err_addr", a_fea, m_log_a);
`endif
    endtask

    task automatic cycle();
        @(posedge clk);
        model_update();
        #1;
        compare_all();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        model_reset();
        compare_all();
        @(posedge clk);
        #1;
        compare_all();
        mem_read  = 1'b0;
        clear_err = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        model_reset();
        m_edge = 0;
        #2;
        compare_all();
        @(posedge clk);
        #1;
        compare_all();
        @(negedge clk);
        rst_n = 1'b1;

        // 1: good return
        mem_read = 1'b1; mem_address = 16'h1234; cycle();
        mem_read = 1'b0; mem_data_out = 9'h0A5; cycle();
        chk("t1_data", a_data, 8'hA5);
        chk("t1_perr", a_perr, 1'b0);
        chk("t1_count", a_cnt, 16'h0000);
        out_ready = 1'b1; cycle();
        out_ready = 1'b0;

        // 2: corrupt return
        mem_read = 1'b1; mem_address = 16'h00FF; cycle();
        mem_read = 1'b0; mem_data_out = 9'h1A5; cycle();
        chk("t2_perr", a_perr, 1'b1);
        chk("t2_count", a_cnt, 16'h0001);
`ifdef MY_MEM_ERR_LOG_EN
        chk("t2_log", a_fea, 16'h00FF);
`endif
        out_ready = 1'b1; cycle();
        out_ready = 1'b0;

        // 3: five reads into a stalled FIFO
        for (int k = 0; k < 6; k++) begin
            mem_read = (k < 5);
            mem_address = 16'h3000 + 16'(k);
            mem_data_out = word(8'h40 + 8'(k), 1'b0);
            cycle();
        end
        mem_read = 1'b0;
        chk("t3_level", a_level, 3'd4);
        chk("t3_ovf", a_ovf, 1'b1);
        out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            chk("t3_order", a_addr, 16'h3000 + 16'(k));
            cycle();
        end
        out_ready = 1'b0;
        clear_err = 1'b1; cycle();
        clear_err = 1'b0;
        chk("t3_clear", a_ovf, 1'b0);

        // 4: push and pop in the same cycle while full
        for (int k = 0; k < 5; k++) begin
            mem_read = 1'b1;
            mem_address = (k < 4) ? 16'h4000 + 16'(k) : 16'h4444;
            mem_data_out = word(8'h60 + 8'(k), 1'b0);
            cycle();
        end
        mem_read = 1'b0; out_ready = 1'b1; mem_data_out = word(8'h77, 1'b0); cycle();
        chk("t4_level", a_level, 3'd4);
        chk("t4_ovf", a_ovf, 1'b0);
        for (int k = 0; k < 3; k++) cycle();
        chk("t4_tail", a_addr, 16'h4444);
        for (int k = 0; k < 2; k++) cycle();

        // 5: saturation then clear with a simultaneous error
        clear_err = 1'b1; cycle();
        clear_err = 1'b0;
        for (int k = 0; k < 5; k++) begin
            mem_read = (k < 4);
            mem_address = 16'h5000 + 16'(k);
            mem_data_out = word(8'h11 * 8'(k), 1'b1);
            cycle();
        end
        chk("t5_sat", b_cnt, 2'b11);
        chk("t5_cnt16", a_cnt, 16'd4);
        mem_read = 1'b1; mem_address = 16'h5555; cycle();
        mem_read = 1'b0; clear_err = 1'b1; mem_data_out = word(8'h3C, 1'b1); cycle();
        clear_err = 1'b0;
        chk("t5_clear_sat", b_cnt, 2'b01);
        chk("t5_clear_cnt16", a_cnt, 16'd1);
        for (int k = 0; k < 3; k++) cycle();

        // 6: reset with entries buffered and a read in flight
        out_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            mem_read = 1'b1;
            mem_address = 16'h6000 + 16'(k);
            mem_data_out = word(8'h90 + 8'(k), 1'b0);
            cycle();
        end
        do_reset();
        chk("t6_valid", a_valid, 1'b0);
        chk("t6_level", a_level, 3'd0);
        mem_data_out = word(8'hEE, 1'b1);
        for (int k = 0; k < 3; k++) cycle();
        chk("t6_stale", a_valid, 1'b0);
        chk("t6_cnt", a_cnt, 16'd0);

        // Random traffic
        for (int n = 0; n < 3000; n++) begin
            mem_read     = ($urandom_range(0, 99) < 70);
            mem_address  = 16'($urandom);
            mem_data_out = word(8'($urandom), ($urandom_range(0, 9) == 0));
            out_ready    = ($urandom_range(0, 99) < 45);
            clear_err    = ($urandom_range(0, 59) == 0);
            if ($urandom_range(0, 799) == 0) do_reset();
            else cycle();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
